// File: rtl/reg_rw_cbit_req_seq.sv
// Request sequencer in front of the read-set-bit BRAM data port: issues accepted requests,
// tracks the fixed 2-cycle read latency and returns in-order responses through a credit-limited FIFO.
module reg_rw_cbit_req_seq #(
   parameter int L2_DEPTH   = 8,
   parameter int WIDTH      = 32,
   parameter int RESP_DEPTH = 4
) (
   input  logic                clk,
   input  logic                resetn,
   input  logic                req_valid,
   output logic                req_ready,
   input  logic                req_write,
   input  logic [L2_DEPTH-1:0] req_index,
   input  logic [WIDTH-1:0]    req_data,
   output logic                resp_valid,
   input  logic                resp_ready,
   output logic [WIDTH-1:0]    resp_data,
   output logic                resp_write,
   output logic                bram_en,
   output logic                bram_we,
   output logic [L2_DEPTH-1:0] bram_addr,
   output logic [WIDTH-1:0]    bram_din,
   output logic                bram_rst,
   output logic                bram_regce,
   input  logic [WIDTH-1:0]    bram_dout,
   output logic [31:0]         rd_count,
   output logic [31:0]         wr_count
);

   localparam int PW = $clog2(RESP_DEPTH);

   logic                ready_q, ready_d;
   logic                v1_q, v1_d, w1_q, w1_d;
   logic                v2_q, v2_d, w2_q, w2_d;
   logic [PW-1:0]       wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic [PW:0]         cnt_q, cnt_d;
   logic [PW+1:0]       credit_s;
   logic [31:0]         rd_cnt_q, rd_cnt_d, wr_cnt_q, wr_cnt_d;
   logic [WIDTH:0]      fifo_q [RESP_DEPTH];
   logic                accept_s, push_s, pop_s;

   assign accept_s   = req_valid & ready_q;
   assign push_s     = v2_q;
   assign pop_s      = resp_valid & resp_ready;

   assign req_ready  = ready_q;
   assign resp_valid = (cnt_q != '0);
   assign resp_write = fifo_q[rd_ptr_q][WIDTH];
   assign resp_data  = fifo_q[rd_ptr_q][WIDTH-1:0];
   assign rd_count   = rd_cnt_q;
   assign wr_count   = wr_cnt_q;

   // The BRAM port sees the request only in the accepting cycle; otherwise it is idle and zero.
   assign bram_en    = accept_s;
   assign bram_we    = accept_s & req_write;
   assign bram_addr  = accept_s ? req_index : '0;
   assign bram_din   = accept_s ? req_data : '0;
   assign bram_rst   = 1'b0;
   assign bram_regce = 1'b1;

   // Next-state: latency pipe, FIFO bookkeeping, credit and saturating counters.
   always_comb begin
      v1_d     = accept_s;
      w1_d     = req_write;
      v2_d     = v1_q;
      w2_d     = w1_q;
      cnt_d    = cnt_q;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      rd_cnt_d = rd_cnt_q;
      wr_cnt_d = wr_cnt_q;
      if (push_s) begin
         wr_ptr_d = wr_ptr_q + PW'(1);
      end else begin
         wr_ptr_d = wr_ptr_q;
      end
      if (pop_s) begin
         rd_ptr_d = rd_ptr_q + PW'(1);
      end else begin
         rd_ptr_d = rd_ptr_q;
      end
      case ({push_s, pop_s})
         2'b10:   cnt_d = cnt_q + (PW+1)'(1);
         2'b01:   cnt_d = cnt_q - (PW+1)'(1);
         default: cnt_d = cnt_q;
      endcase
      // Credit is computed from next-cycle occupancy, so a pop frees a slot one cycle later.
      credit_s = {1'b0, cnt_d} + (PW+2)'(v1_d) + (PW+2)'(v2_d);
      ready_d  = (credit_s < (PW+2)'(RESP_DEPTH));
      if (accept_s && !req_write && (rd_cnt_q != 32'hFFFF_FFFF)) begin
         rd_cnt_d = rd_cnt_q + 32'd1;
      end else begin
         rd_cnt_d = rd_cnt_q;
      end
      if (accept_s && req_write && (wr_cnt_q != 32'hFFFF_FFFF)) begin
         wr_cnt_d = wr_cnt_q + 32'd1;
      end else begin
         wr_cnt_d = wr_cnt_q;
      end
   end

   // Control state registers.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         ready_q  <= 1'b0;
         v1_q     <= 1'b0;
         w1_q     <= 1'b0;
         v2_q     <= 1'b0;
         w2_q     <= 1'b0;
         cnt_q    <= '0;
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         rd_cnt_q <= 32'd0;
         wr_cnt_q <= 32'd0;
      end else begin
         ready_q  <= ready_d;
         v1_q     <= v1_d;
         w1_q     <= w1_d;
         v2_q     <= v2_d;
         w2_q     <= w2_d;
         cnt_q    <= cnt_d;
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         rd_cnt_q <= rd_cnt_d;
         wr_cnt_q <= wr_cnt_d;
      end
   end

   // Response storage; cleared so the head reads as zero out of reset.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         for (int i = 0; i < RESP_DEPTH; i++) begin
            fifo_q[i] <= '0;
         end
      end else if (push_s) begin
         fifo_q[wr_ptr_q] <= {w2_q, bram_dout};
      end
   end

endmodule

// File: tb/tb_reg_rw_cbit_req_seq.sv
// Directed + random bench for reg_rw_cbit_req_seq with a behavioural 2-cycle BRAM and a response scoreboard.
module tb_reg_rw_cbit_req_seq;

   typedef struct packed {
      logic        w;
      logic [31:0] d;
   } exp_t;

   logic        clk = 1'b0;
   logic        resetn;
   logic        req_valid, req_ready, req_write;
   logic [7:0]  req_index;
   logic [31:0] req_data;
   logic        resp_valid, resp_ready, resp_write;
   logic [31:0] resp_data;
   logic        bram_en, bram_we, bram_rst, bram_regce;
   logic [7:0]  bram_addr;
   logic [31:0] bram_din, bram_dout;
   logic [31:0] rd_count, wr_count;

   logic [31:0] bmem [256];
   logic [31:0] bq1;
   logic [31:0] ref_mem [256];
   exp_t        sb [$];
   int          checks = 0;
   int          failures = 0;
   int          pops = 0;
   int          accepts = 0;
   int          p0, a0;

   reg_rw_cbit_req_seq #(.L2_DEPTH(8), .WIDTH(32), .RESP_DEPTH(4)) dut (
      .clk(clk), .resetn(resetn),
      .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
      .req_index(req_index), .req_data(req_data),
      .resp_valid(resp_valid), .resp_ready(resp_ready),
      .resp_data(resp_data), .resp_write(resp_write),
      .bram_en(bram_en), .bram_we(bram_we), .bram_addr(bram_addr), .bram_din(bram_din),
      .bram_rst(bram_rst), .bram_regce(bram_regce), .bram_dout(bram_dout),
      .rd_count(rd_count), .wr_count(wr_count)
   );

   always #5 clk = ~clk;

   // Write-first BRAM port with internal register then output register.
   always @(posedge clk) begin
      if (bram_en) begin
         if (bram_we) begin
            bmem[bram_addr] <= bram_din;
            bq1 <= bram_din;
         end else begin
            bq1 <= bmem[bram_addr];
         end
      end
      if (bram_regce) bram_dout <= bq1;
   end

   function automatic logic [31:0] init_val(int i);
      return 32'h5A00_0000 ^ (32'(i) * 32'h0001_0203);
   endfunction

   task automatic check(string tag, logic [63:0] obs, logic [63:0] expv);
      checks++;
      assert (obs === expv) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
      end
   endtask

   // One clock: observe handshakes at negedge, update scoreboard, return at posedge+1.
   task automatic tick();
      exp_t e;
      @(negedge clk);
      if (resp_valid) begin
         if (sb.size() == 0) begin
            check("resp_unexpected", 64'd1, 64'd0);
         end else begin
            e = sb[0];
            check("resp_write", 64'(resp_write), 64'(e.w));
            check("resp_data", 64'(resp_data), 64'(e.d));
            if (resp_ready) begin
               void'(sb.pop_front());
               pops++;
            end
         end
      end
      if (req_valid && req_ready) begin
         accepts++;
         check("bram_en", 64'(bram_en), 64'd1);
         check("bram_we", 64'(bram_we), 64'(req_write));
         check("bram_addr", 64'(bram_addr), 64'(req_index));
         check("bram_din", 64'(bram_din), 64'(req_data));
         if (req_write) begin
            ref_mem[req_index] = req_data;
            e.w = 1'b1;
            e.d = req_data;
         end else begin
            e.w = 1'b0;
            e.d = ref_mem[req_index];
         end
         sb.push_back(e);
         check("fifo_overflow", 64'(sb.size() <= 4), 64'd1);
      end else begin
         check("bram_en_idle", 64'(bram_en), 64'd0);
      end
      @(posedge clk);
      #1;
   endtask

   task automatic wait_ready();
      for (int i = 0; i < 50 && !req_ready; i++) tick();
      check("ready_wait", 64'(req_ready), 64'd1);
   endtask

   task automatic drain();
      req_valid  = 1'b0;
      resp_ready = 1'b1;
      for (int i = 0; i < 100 && sb.size() != 0; i++) tick();
      check("drain_empty", 64'(sb.size()), 64'd0);
   endtask

   task automatic set_req(logic v, logic w, logic [7:0] idx, logic [31:0] d);
      req_valid = v;
      req_write = w;
      req_index = idx;
      req_data  = d;
   endtask

   task automatic check_reset_outputs(string tag);
      check({tag, "_req_ready"}, 64'(req_ready), 64'd0);
      check({tag, "_resp_valid"}, 64'(resp_valid), 64'd0);
      check({tag, "_bram_en"}, 64'(bram_en), 64'd0);
      check({tag, "_bram_we"}, 64'(bram_we), 64'd0);
      check({tag, "_bram_addr"}, 64'(bram_addr), 64'd0);
      check({tag, "_bram_din"}, 64'(bram_din), 64'd0);
      check({tag, "_resp_data"}, 64'(resp_data), 64'd0);
      check({tag, "_resp_write"}, 64'(resp_write), 64'd0);
      check({tag, "_rd_count"}, 64'(rd_count), 64'd0);
      check({tag, "_wr_count"}, 64'(wr_count), 64'd0);
   endtask

   initial begin
      for (int i = 0; i < 256; i++) begin
         bmem[i]    = init_val(i);
         ref_mem[i] = init_val(i);
      end
      bq1        = 32'd0;
      bram_dout  = 32'd0;
      resetn     = 1'b0;
      resp_ready = 1'b0;
      set_req(1'b1, 1'b1, 8'hFF, 32'hFFFF_FFFF);

      // Reset state, with a request held on the input.
      #12;
      check_reset_outputs("reset");
      check("bram_rst", 64'(bram_rst), 64'd0);
      check("bram_regce", 64'(bram_regce), 64'd1);
      set_req(1'b0, 1'b0, 8'd0, 32'd0);
      @(negedge clk);
      resetn = 1'b1;
      @(posedge clk);
      #1;
      resp_ready = 1'b1;
      wait_ready();

      // Test 1: write idx 5 then read idx 5; exact 3-cycle response latency.
      set_req(1'b1, 1'b1, 8'd5, 32'hDEAD_BEEF);
      tick();
      set_req(1'b1, 1'b0, 8'd5, 32'h0);
      tick();
      set_req(1'b0, 1'b0, 8'd0, 32'h0);
      check("t1_no_resp_T2", 64'(resp_valid), 64'd0);
      tick();
      check("t1_resp_valid_T3", 64'(resp_valid), 64'd1);
      check("t1_resp_write_T3", 64'(resp_write), 64'd1);
      check("t1_resp_data_T3", 64'(resp_data), 64'hDEAD_BEEF);
      tick();
      check("t1_resp_valid_T4", 64'(resp_valid), 64'd1);
      check("t1_resp_write_T4", 64'(resp_write), 64'd0);
      check("t1_resp_data_T4", 64'(resp_data), 64'hDEAD_BEEF);
      drain();
      check("t1_wr_count", 64'(wr_count), 64'd1);
      check("t1_rd_count", 64'(rd_count), 64'd1);

      // Test 2: back-to-back reads idx 0..15 with constant resp_ready.
      wait_ready();
      p0 = pops;
      for (int i = 0; i < 16; i++) begin
         set_req(1'b1, 1'b0, 8'(i), 32'h0);
         check("t2_ready_steady", 64'(req_ready), 64'd1);
         tick();
      end
      set_req(1'b0, 1'b0, 8'd0, 32'h0);
      repeat (3) tick();
      check("t2_pops_one_per_cycle", 64'(pops - p0), 64'd16);
      drain();

      // Test 3: credit limit with resp_ready low, then recovery after the first pop.
      resp_ready = 1'b0;
      a0 = accepts;
      for (int i = 0; i < 10; i++) begin
         set_req(1'b1, 1'b0, 8'(20 + i), 32'h0);
         tick();
      end
      check("t3_accepted", 64'(accepts - a0), 64'd4);
      check("t3_ready_low", 64'(req_ready), 64'd0);
      set_req(1'b0, 1'b0, 8'd0, 32'h0);
      resp_ready = 1'b1;
      p0 = pops;
      check("t3_ready_pop_cycle", 64'(req_ready), 64'd0);
      tick();
      check("t3_ready_after_pop", 64'(req_ready), 64'd1);
      drain();
      check("t3_pops", 64'(pops - p0), 64'd4);

      // Test 4: random traffic on both sides against the reference model.
      a0 = accepts;
      for (int c = 0; c < 60000 && (accepts - a0) < 10000; c++) begin
         req_valid  = ($urandom_range(0, 3) != 0);
         req_write  = 1'($urandom_range(0, 1));
         req_index  = 8'($urandom_range(0, 15));
         req_data   = $urandom;
         resp_ready = ($urandom_range(0, 3) != 0);
         tick();
      end
      check("t4_ops_done", 64'(accepts - a0), 64'd10000);
      drain();

      // Test 5: reset with 2 responses queued and 2 in flight.
      resp_ready = 1'b0;
      a0 = accepts;
      for (int i = 0; i < 4; i++) begin
         set_req(1'b1, 1'b0, 8'(40 + i), 32'h0);
         tick();
      end
      check("t5_accepted", 64'(accepts - a0), 64'd4);
      check("t5_queued_before_reset", 64'(resp_valid), 64'd1);
      #2;
      resetn = 1'b0;
      #1;
      check_reset_outputs("t5_reset");
      sb.delete();
      repeat (2) @(posedge clk);
      @(negedge clk);
      req_valid = 1'b0;
      resetn    = 1'b1;
      @(posedge clk);
      #1;
      resp_ready = 1'b1;
      for (int i = 0; i < 10; i++) begin
         check("t5_no_stray_resp", 64'(resp_valid), 64'd0);
         tick();
      end
      check("t5_rd_count", 64'(rd_count), 64'd0);

      // Test 6: rd_count saturation from a preloaded value.
      wait_ready();
      force dut.rd_cnt_q = 32'hFFFF_FFFE;
      #1;
      release dut.rd_cnt_q;
      check("t6_preload", 64'(rd_count), 64'hFFFF_FFFE);
      set_req(1'b1, 1'b0, 8'd7, 32'h0);
      tick();
      check("t6_first_read", 64'(rd_count), 64'hFFFF_FFFF);
      tick();
      tick();
      set_req(1'b0, 1'b0, 8'd0, 32'h0);
      tick();
      check("t6_saturated", 64'(rd_count), 64'hFFFF_FFFF);
      drain();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
